// File: rtl/decode_in_issue_pkg.sv
// Shared types and constants for the decode_in issue stage: fetch FSM states,
// queue entry layout and the LC-3 reset PC.
package decode_in_issue_pkg;

    localparam logic [15:0] LC3_RESET_PC = 16'h3000;
    localparam logic [2:0]  SR_RESET     = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } fetch_state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] npc;
    } issue_entry_t;

endpackage

// File: rtl/decode_in_issue_fifo.sv
// Small synchronous FIFO of issue entries. A push into a full FIFO is accepted
// only when a pop happens in the same cycle; clear empties it in one cycle.
module decode_in_issue_fifo
    import decode_in_issue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  issue_entry_t               din,
    input  logic                       pop,
    output issue_entry_t               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    issue_entry_t mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset && !clear && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/decode_in_issue.sv
// Instruction-issue stage feeding decode_in: fetches words from imem, queues
// them and issues one per en_decode pulse. DECODE_IN_CC_BYPASS_EN makes Sr bypass cc_in.
//
// state | meaning
// IDLE  | no request outstanding; start one when fetch enabled and queue has room
// REQ   | imem_rd high for one cycle at imem_addr = pc
// WAIT  | request outstanding; capture (or drop) the word on imem_valid
module decode_in_issue
    import decode_in_issue_pkg::*;
#(
    parameter logic [15:0] RESET_PC = LC3_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_fetch,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [15:0] taddr,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_dout,
    input  logic        imem_valid,
    input  logic [2:0]  cc_in,
    input  logic        cc_we,
    output logic [15:0] instr_dout,
    output logic [15:0] npc_in,
    output logic [2:0]  Sr,
    output logic        en_decode
);

    localparam int CW = $clog2(QDEPTH + 1);

    fetch_state_t  state_q, state_d;
    logic [15:0]   pc_q, pc_d;
    logic          drop_q, drop_d;
    logic          push, pop;
    issue_entry_t  push_entry, head;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] count;
    logic [2:0]    sr_q;

    // A redirect wins over issue: nothing pops in the cycle the queue is flushed.
    assign pop = !br_taken && !stall && !fifo_empty;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        push       = 1'b0;
        push_entry = '{instr: imem_dout, npc: pc_q + 16'd1};
        case (state_q)
            IDLE: begin
                if (enable_fetch && !br_taken && (count < CW'(QDEPTH))) state_d = REQ;
            end
            REQ: begin
                state_d = WAIT;
                if (br_taken) drop_d = 1'b1;
            end
            WAIT: begin
                if (imem_valid) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    if (!drop_q && !br_taken && (!fifo_full || pop)) begin
                        push = 1'b1;
                        pc_d = pc_q + 16'd1;
                    end
                end else if (br_taken) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (br_taken) pc_d = taddr;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            instr_dout <= 16'h0000;
            npc_in     <= 16'h0000;
            en_decode  <= 1'b0;
            sr_q       <= SR_RESET;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            drop_q    <= drop_d;
            en_decode <= pop;
            if (pop) begin
                instr_dout <= head.instr;
                npc_in     <= head.npc;
            end
            if (cc_we) sr_q <= cc_in;
        end
    end

    assign imem_rd   = (state_q == REQ);
    assign imem_addr = imem_rd ? pc_q : 16'h0000;

`ifdef DECODE_IN_CC_BYPASS_EN
    assign Sr = cc_we ? cc_in : sr_q;
`else
    assign Sr = sr_q;
`endif

    decode_in_issue_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (br_taken),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

endmodule

// File: tb/tb_decode_in_issue.sv
// Directed bench for decode_in_issue with a scoreboard of expected issues fed
// from the memory responses; a second instance covers RESET_PC wrap-around.
module tb_decode_in_issue;

    logic        clock = 1'b0;
    logic        reset, enable_fetch, stall, br_taken, cc_we;
    logic [15:0] taddr;
    logic [2:0]  cc_in;
    logic        imem_rd, imem_valid, en_decode;
    logic [15:0] imem_addr, imem_dout, instr_dout, npc_in;
    logic [2:0]  Sr;

    logic        auto_mem;
    logic        auto_valid = 1'b0;
    logic [15:0] auto_dout  = 16'h0000;
    logic        man_valid;
    logic [15:0] man_dout;

    logic        imem_rd2, en_decode2;
    logic        imem_valid2 = 1'b0;
    logic [15:0] imem_addr2, instr_dout2, npc_in2;
    logic [2:0]  Sr2;

    logic [31:0] exp_q[$];
    logic [31:0] sb_e;
    int unsigned epoch = 0, pend_epoch = 0;
    logic [15:0] pend_addr = 16'h0000;
    logic        pend_live = 1'b0;

    int checks = 0;
    int errors = 0;
    int n_rd, n_en;

    always #5 clock = ~clock;

    assign imem_valid = auto_mem ? auto_valid : man_valid;
    assign imem_dout  = auto_mem ? auto_dout  : man_dout;

    decode_in_issue u_dut (
        .clock(clock), .reset(reset), .enable_fetch(enable_fetch), .stall(stall),
        .br_taken(br_taken), .taddr(taddr), .imem_rd(imem_rd), .imem_addr(imem_addr),
        .imem_dout(imem_dout), .imem_valid(imem_valid), .cc_in(cc_in), .cc_we(cc_we),
        .instr_dout(instr_dout), .npc_in(npc_in), .Sr(Sr), .en_decode(en_decode)
    );

    decode_in_issue #(.RESET_PC(16'hFFFF)) u_dut_wrap (
        .clock(clock), .reset(reset), .enable_fetch(enable_fetch), .stall(1'b0),
        .br_taken(1'b0), .taddr(16'h0000), .imem_rd(imem_rd2), .imem_addr(imem_addr2),
        .imem_dout(16'h7777), .imem_valid(imem_valid2), .cc_in(3'b000), .cc_we(1'b0),
        .instr_dout(instr_dout2), .npc_in(npc_in2), .Sr(Sr2), .en_decode(en_decode2)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a == 16'h3000) ? 16'h1234 : (a ^ 16'h5A5A);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Single-cycle memories: answer every request in the following cycle.
    always @(posedge clock) begin
        auto_valid  <= imem_rd;
        auto_dout   <= mem_word(imem_addr);
        imem_valid2 <= imem_rd2;
    end

    // Scoreboard producer: a response counts only if no reset or redirect
    // happened since its request was issued.
    always @(posedge clock) begin
        if (!reset || br_taken) begin
            exp_q.delete();
            epoch <= epoch + 1;
        end else if (imem_valid && pend_live && pend_epoch == epoch) begin
            exp_q.push_back({imem_dout, pend_addr + 16'd1});
        end
        if (!reset) pend_live <= 1'b0;
        else if (imem_rd) begin
            pend_addr  <= imem_addr;
            pend_epoch <= epoch;
            pend_live  <= 1'b1;
        end else if (imem_valid) pend_live <= 1'b0;
    end

    always @(negedge clock) begin
        if (reset && en_decode) begin
            chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                sb_e = exp_q.pop_front();
                chk("sb_instr", 32'(instr_dout), 32'(sb_e[31:16]));
                chk("sb_npc", 32'(npc_in), 32'(sb_e[15:0]));
            end
        end
    end

    initial begin
        reset = 1'b0; enable_fetch = 1'b0; stall = 1'b0; br_taken = 1'b0;
        taddr = 16'h0000; cc_in = 3'b000; cc_we = 1'b0;
        auto_mem = 1'b1; man_valid = 1'b0; man_dout = 16'h0000;
        repeat (2) tick();
        chk("rst_imem_rd", 32'(imem_rd), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'h0);
        chk("rst_instr", 32'(instr_dout), 32'h0);
        chk("rst_npc", 32'(npc_in), 32'h0);
        chk("rst_sr", 32'(Sr), 32'b010);
        chk("rst_en", 32'(en_decode), 32'd0);

        // First fetch and issue, with the wrap-around instance in lockstep
        enable_fetch = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < 20 && !imem_valid; i++) tick();
        chk("t1_valid_seen", 32'(imem_valid), 32'd1);
        tick();
        chk("t1_no_issue_yet", 32'(en_decode), 32'd0);
        chk("t1_sr_before", 32'(Sr), 32'b010);
        tick();
        chk("t1_en", 32'(en_decode), 32'd1);
        chk("t1_instr", 32'(instr_dout), 32'h1234);
        chk("t1_npc", 32'(npc_in), 32'h3001);
        chk("t1_next_addr", 32'(imem_addr), 32'h3001);
        chk("wrap_en", 32'(en_decode2), 32'd1);
        chk("wrap_instr", 32'(instr_dout2), 32'h7777);
        chk("wrap_npc", 32'(npc_in2), 32'h0000);
        chk("wrap_rd2", 32'(imem_rd2), 32'd1);
        chk("wrap_addr2", 32'(imem_addr2), 32'h0000);
        chk("wrap_sr", 32'(Sr2), 32'b010);
        n_en = 0;
        repeat (12) begin tick(); n_en += int'(en_decode); end
        chk("t1_throughput", 32'(n_en), 32'd4);

        // Condition-code write: same cycle only with the bypass
        cc_in = 3'b100; cc_we = 1'b1;
        #2;
`ifdef DECODE_IN_CC_BYPASS_EN
        chk("cc_same_cycle", 32'(Sr), 32'b100);
`else
        chk("cc_same_cycle", 32'(Sr), 32'b010);
`endif
        tick();
        cc_we = 1'b0;
        chk("cc_next_cycle", 32'(Sr), 32'b100);
        cc_in = 3'b111; cc_we = 1'b1;
        tick();
        cc_we = 1'b0;
        chk("cc_non_onehot", 32'(Sr), 32'b111);

        // Stall fills the queue; fetching stops at QDEPTH captures
        reset = 1'b0; stall = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        n_rd = 0; n_en = 0;
        repeat (10) begin tick(); n_rd += int'(imem_rd); n_en += int'(en_decode); end
        chk("stall_rd_count", 32'(n_rd), 32'd2);
        chk("stall_no_issue", 32'(n_en), 32'd0);
        chk("stall_rd_idle", 32'(imem_rd), 32'd0);
        stall = 1'b0;
        tick();
        chk("stall_rel_en0", 32'(en_decode), 32'd1);
        chk("stall_rel_i0", 32'(instr_dout), 32'h1234);
        tick();
        chk("stall_rel_en1", 32'(en_decode), 32'd1);
        chk("stall_rel_i1", 32'(instr_dout), 32'(mem_word(16'h3001)));
        chk("stall_rel_n1", 32'(npc_in), 32'h3002);
        tick();
        for (int i = 0; i < 20 && !en_decode; i++) tick();
        chk("stall_third_en", 32'(en_decode), 32'd1);
        chk("stall_third_npc", 32'(npc_in), 32'h3003);
        stall = 1'b1;
        tick();
        chk("stall_ends_pulse", 32'(en_decode), 32'd0);
        stall = 1'b0;

        // Redirect while WAIT; late word must be dropped and the queue flushed
        reset = 1'b0; auto_mem = 1'b0; stall = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        for (int i = 0; i < 10 && !imem_rd; i++) tick();
        chk("br_req0_addr", 32'(imem_addr), 32'h3000);
        tick();
        man_valid = 1'b1; man_dout = 16'h1111;
        tick();
        man_valid = 1'b0;
        for (int i = 0; i < 10 && !imem_rd; i++) tick();
        chk("br_req1_addr", 32'(imem_addr), 32'h3001);
        tick();
        br_taken = 1'b1; taddr = 16'h4000;
        tick();
        br_taken = 1'b0; stall = 1'b0;
        chk("br_en_low", 32'(en_decode), 32'd0);
        tick();
        man_valid = 1'b1; man_dout = 16'hDEAD;
        tick();
        man_valid = 1'b0;
        n_en = int'(en_decode);
        for (int i = 0; i < 10 && !imem_rd; i++) begin tick(); n_en += int'(en_decode); end
        chk("br_next_addr", 32'(imem_addr), 32'h4000);
        chk("br_nothing_issued", 32'(n_en), 32'd0);
        tick();
        man_valid = 1'b1; man_dout = 16'hBEEF;
        tick();
        man_valid = 1'b0;
        tick();
        chk("br_target_en", 32'(en_decode), 32'd1);
        chk("br_target_instr", 32'(instr_dout), 32'hBEEF);
        chk("br_target_npc", 32'(npc_in), 32'h4001);

        // Reset during WAIT, then a stray response
        for (int i = 0; i < 10 && !imem_rd; i++) tick();
        chk("rw_req_seen", 32'(imem_rd), 32'd1);
        tick();
        reset = 1'b0;
        tick();
        chk("rw_rd", 32'(imem_rd), 32'd0);
        chk("rw_addr", 32'(imem_addr), 32'h0);
        chk("rw_instr", 32'(instr_dout), 32'h0);
        chk("rw_npc", 32'(npc_in), 32'h0);
        chk("rw_sr", 32'(Sr), 32'b010);
        chk("rw_en", 32'(en_decode), 32'd0);
        reset = 1'b1; man_valid = 1'b1; man_dout = 16'hBAD1;
        tick();
        man_valid = 1'b0;
        chk("rw_new_req", 32'(imem_rd), 32'd1);
        chk("rw_new_addr", 32'(imem_addr), 32'h3000);
        chk("rw_stray_ignored", 32'(en_decode), 32'd0);
        tick();
        man_valid = 1'b1; man_dout = 16'h2222;
        tick();
        man_valid = 1'b0;
        tick();
        chk("rw_issue_en", 32'(en_decode), 32'd1);
        chk("rw_issue_instr", 32'(instr_dout), 32'h2222);
        chk("rw_issue_npc", 32'(npc_in), 32'h3001);

        enable_fetch = 1'b0;
        repeat (3) tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
